// File: rtl/daq_frame_rx.sv
// Receive-side checker for the 19-bit ALCT DAQ stream: frames the stream, validates
// header/trailer/count words, extracts header fields and CRC words, forwards body words.
module daq_frame_rx #(
  parameter int MAX_WORDS = 2047
) (
  input  logic        clk,
  input  logic        hard_rst,
  input  logic [18:0] daqp,
  output logic [18:0] pay_data,
  output logic        pay_valid,
  output logic [11:0] bxn_l1a,
  output logic [11:0] l1a_count,
  output logic [11:0] readout_count,
  output logic [18:0] crc0,
  output logic [18:0] crc1,
  output logic [10:0] frame_len,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [4:0]  err,
  output logic [15:0] good_frames,
  output logic [15:0] bad_frames,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR1 = 3'd1;
  localparam logic [2:0] S_HDR2 = 3'd2;
  localparam logic [2:0] S_HDR3 = 3'd3;
  localparam logic [2:0] S_BODY = 3'd4;
  localparam logic [2:0] S_CRC0 = 3'd5;
  localparam logic [2:0] S_CRC1 = 3'd6;
  localparam logic [2:0] S_WCNT = 3'd7;

  localparam logic [18:0] HDR_MARK = 19'h0DB0A;
  localparam logic [18:0] TRL_MARK = 19'h0DE0D;
  localparam logic [10:0] MAX_WC   = 11'(MAX_WORDS);

  logic [2:0]  state_q, state_d;
  logic [10:0] wc_q, wc_d;
  logic [4:0]  err_run_q, err_run_d;
  logic [4:0]  err_q, err_d;
  logic [18:0] pay_data_q, pay_data_d;
  logic        pay_valid_q, pay_valid_d;
  logic [11:0] bxn_q, bxn_d, l1a_q, l1a_d, rdc_q, rdc_d;
  logic [18:0] crc0_q, crc0_d, crc1_q, crc1_d;
  logic [10:0] frame_len_q, frame_len_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_ok_q, frame_ok_d;
  logic [15:0] good_q, good_d, bad_q, bad_d;

  logic        is_idle, is_hdr, is_trl, pfx_ok, tag_ok;
  logic [10:0] wc_inc;
  logic        fin, restart;
  logic [4:0]  fin_err;

  assign is_idle = daqp[18];
  assign is_hdr  = (daqp == HDR_MARK);
  assign is_trl  = (daqp == TRL_MARK);
  assign pfx_ok  = (daqp[18:12] == 7'h0D);
  assign tag_ok  = (daqp[18:11] == 8'b00111010);
  assign wc_inc  = wc_q + 11'd1;

  always_comb begin
    state_d      = state_q;
    wc_d         = wc_q;
    err_run_d    = err_run_q;
    pay_data_d   = pay_data_q;
    pay_valid_d  = 1'b0;
    bxn_d        = bxn_q;
    l1a_d        = l1a_q;
    rdc_d        = rdc_q;
    crc0_d       = crc0_q;
    crc1_d       = crc1_q;
    frame_len_d  = frame_len_q;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    good_d       = good_q;
    bad_d        = bad_q;
    fin          = 1'b0;
    restart      = 1'b0;
    fin_err      = 5'd0;

    case (state_q)
      S_IDLE: begin
        if (is_hdr) begin
          state_d   = S_HDR1;
          wc_d      = 11'd1;
          err_run_d = 5'd0;
        end
      end
      default: begin
        if (is_idle) begin
          err_run_d[0] = 1'b1;
          fin          = 1'b1;
          fin_err      = err_run_d;
          frame_len_d  = wc_q;
          state_d      = S_IDLE;
        end else if (state_q == S_BODY && is_hdr) begin
          // The marker that kills this frame is also the first word of the next one.
          restart     = 1'b1;
          fin         = 1'b1;
          fin_err     = err_run_q | 5'b10000;
          frame_len_d = wc_q;
          err_run_d   = 5'd0;
          wc_d        = 11'd1;
          state_d     = S_HDR1;
        end else if (state_q != S_WCNT && wc_inc == MAX_WC) begin
          err_run_d[4] = 1'b1;
          fin          = 1'b1;
          fin_err      = err_run_d;
          wc_d         = wc_inc;
          frame_len_d  = wc_inc;
          state_d      = S_IDLE;
        end else begin
          wc_d = wc_inc;
          case (state_q)
            S_HDR1: begin
              if (!pfx_ok) err_run_d[1] = 1'b1;
              bxn_d   = daqp[11:0];
              state_d = S_HDR2;
            end
            S_HDR2: begin
              if (!pfx_ok) err_run_d[1] = 1'b1;
              l1a_d   = daqp[11:0];
              state_d = S_HDR3;
            end
            S_HDR3: begin
              if (!pfx_ok) err_run_d[1] = 1'b1;
              rdc_d   = daqp[11:0];
              state_d = S_BODY;
            end
            S_BODY: begin
              if (is_trl) begin
                state_d = S_CRC0;
              end else begin
                pay_data_d  = daqp;
                pay_valid_d = 1'b1;
              end
            end
            S_CRC0: begin
              crc0_d  = daqp;
              state_d = S_CRC1;
            end
            S_CRC1: begin
              crc1_d  = daqp;
              state_d = S_WCNT;
            end
            default: begin
              if (!tag_ok) err_run_d[2] = 1'b1;
              if (daqp[10:0] != wc_inc) err_run_d[3] = 1'b1;
              frame_len_d = wc_inc;
              fin         = 1'b1;
              fin_err     = err_run_d;
              state_d     = S_IDLE;
            end
          endcase
        end
      end
    endcase

    if (fin) begin
      frame_done_d = 1'b1;
      frame_ok_d   = (fin_err == 5'd0);
      if (fin_err == 5'd0) begin
        if (good_q != 16'hFFFF) good_d = good_q + 16'd1;
      end else begin
        if (bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
      end
    end

    // On a restart the visible flags describe the frame just ended, not the new one.
    err_d = restart ? fin_err : err_run_d;
  end

  always_ff @(posedge clk) begin
    if (!hard_rst) begin
      state_q      <= S_IDLE;
      wc_q         <= 11'd0;
      err_run_q    <= 5'd0;
      err_q        <= 5'd0;
      pay_data_q   <= 19'd0;
      pay_valid_q  <= 1'b0;
      bxn_q        <= 12'd0;
      l1a_q        <= 12'd0;
      rdc_q        <= 12'd0;
      crc0_q       <= 19'd0;
      crc1_q       <= 19'd0;
      frame_len_q  <= 11'd0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      good_q       <= 16'd0;
      bad_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      wc_q         <= wc_d;
      err_run_q    <= err_run_d;
      err_q        <= err_d;
      pay_data_q   <= pay_data_d;
      pay_valid_q  <= pay_valid_d;
      bxn_q        <= bxn_d;
      l1a_q        <= l1a_d;
      rdc_q        <= rdc_d;
      crc0_q       <= crc0_d;
      crc1_q       <= crc1_d;
      frame_len_q  <= frame_len_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
    end
  end

  assign pay_data      = pay_data_q;
  assign pay_valid     = pay_valid_q;
  assign bxn_l1a       = bxn_q;
  assign l1a_count     = l1a_q;
  assign readout_count = rdc_q;
  assign crc0          = crc0_q;
  assign crc1          = crc1_q;
  assign frame_len     = frame_len_q;
  assign frame_done    = frame_done_q;
  assign frame_ok      = frame_ok_q;
  assign err           = err_q;
  assign good_frames   = good_q;
  assign bad_frames    = bad_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_daq_frame_rx.sv
// Scoreboard bench for daq_frame_rx: default instance plus a MAX_WORDS=16 instance
// used for the overlength abort.
module tb_daq_frame_rx;

  localparam logic [18:0] IDLE_W = 19'h40000;
  localparam logic [18:0] CRC_A  = 19'h12345;
  localparam logic [18:0] CRC_B  = 19'h2ABCD;
  localparam logic [7:0]  TAG    = 8'b00111010;

  typedef struct packed {
    logic [4:0]  err;
    logic        ok;
    logic [10:0] len;
    logic [11:0] bxn;
    logic [11:0] l1a;
    logic [11:0] rdc;
    logic [18:0] c0;
    logic [18:0] c1;
    logic [15:0] good;
    logic [15:0] bad;
  } frame_t;

  logic        clk = 1'b0;
  logic        hard_rst = 1'b0;
  logic [18:0] daqp = IDLE_W;
  logic [18:0] daqp16 = IDLE_W;

  logic [18:0] pay_data, pay_data16, crc0, crc1, crc0_16, crc1_16;
  logic        pay_valid, pay_valid16, frame_done, frame_done16, frame_ok, frame_ok16;
  logic [11:0] bxn_l1a, l1a_count, readout_count, bxn16, l1a16, rdc16;
  logic [10:0] frame_len, frame_len16;
  logic [4:0]  err, err16;
  logic [15:0] good_frames, bad_frames, good16, bad16;
  logic [2:0]  state_dbg, state_dbg16;

  logic [18:0] exp_q[$];
  logic [18:0] exp16_q[$];
  frame_t      exp_f[$];
  frame_t      exp16_f[$];
  frame_t      mf, mf16;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] eg = 16'd0, eb = 16'd0, eg16 = 16'd0, eb16 = 16'd0;

  daq_frame_rx dut (
    .clk(clk), .hard_rst(hard_rst), .daqp(daqp),
    .pay_data(pay_data), .pay_valid(pay_valid),
    .bxn_l1a(bxn_l1a), .l1a_count(l1a_count), .readout_count(readout_count),
    .crc0(crc0), .crc1(crc1), .frame_len(frame_len),
    .frame_done(frame_done), .frame_ok(frame_ok), .err(err),
    .good_frames(good_frames), .bad_frames(bad_frames), .state_dbg(state_dbg)
  );

  daq_frame_rx #(.MAX_WORDS(16)) dut16 (
    .clk(clk), .hard_rst(hard_rst), .daqp(daqp16),
    .pay_data(pay_data16), .pay_valid(pay_valid16),
    .bxn_l1a(bxn16), .l1a_count(l1a16), .readout_count(rdc16),
    .crc0(crc0_16), .crc1(crc1_16), .frame_len(frame_len16),
    .frame_done(frame_done16), .frame_ok(frame_ok16), .err(err16),
    .good_frames(good16), .bad_frames(bad16), .state_dbg(state_dbg16)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic send(input logic [18:0] w, input bit sel16);
    if (sel16) begin
      daqp16 = w;
      daqp   = IDLE_W;
    end else begin
      daqp   = w;
      daqp16 = IDLE_W;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    daqp   = IDLE_W;
    daqp16 = IDLE_W;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input bit sel16, input logic [11:0] b, input logic [11:0] l,
                          input logic [11:0] r, input logic [6:0] pfx2);
    send(19'h0DB0A, sel16);
    send({7'h0D, b}, sel16);
    send({pfx2, l}, sel16);
    send({7'h0D, r}, sel16);
  endtask

  task automatic send_body(input bit sel16, input int n, input int npay);
    for (int i = 0; i < n; i++) begin
      logic [18:0] w;
      w = 19'h01000 + 19'(i);
      if (i < npay) begin
        if (sel16) exp16_q.push_back(w);
        else exp_q.push_back(w);
      end
      send(w, sel16);
    end
  endtask

  task automatic send_tail(input bit sel16, input logic [10:0] cnt);
    send(19'h0DE0D, sel16);
    send(CRC_A, sel16);
    send(CRC_B, sel16);
    send({TAG, cnt}, sel16);
  endtask

  task automatic push_frame(input bit sel16, input logic [4:0] e, input logic [10:0] len,
                            input logic [11:0] b, input logic [11:0] l, input logic [11:0] r,
                            input logic [18:0] c0, input logic [18:0] c1);
    frame_t f;
    f.err = e; f.ok = (e == 5'd0); f.len = len;
    f.bxn = b; f.l1a = l; f.rdc = r; f.c0 = c0; f.c1 = c1;
    if (sel16) begin
      if (e == 5'd0) eg16++; else eb16++;
      f.good = eg16; f.bad = eb16;
      exp16_f.push_back(f);
    end else begin
      if (e == 5'd0) eg++; else eb++;
      f.good = eg; f.bad = eb;
      exp_f.push_back(f);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (pay_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL pay_unexpected: got %0h expected none", pay_data);
      end else chk("pay_data", 64'(pay_data), 64'(exp_q.pop_front()));
    end
    if (frame_done) begin
      if (exp_f.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL frame_unexpected: got err %0h expected none", err);
      end else begin
        mf = exp_f.pop_front();
        chk("err", 64'(err), 64'(mf.err));
        chk("frame_ok", 64'(frame_ok), 64'(mf.ok));
        chk("frame_len", 64'(frame_len), 64'(mf.len));
        chk("bxn_l1a", 64'(bxn_l1a), 64'(mf.bxn));
        chk("l1a_count", 64'(l1a_count), 64'(mf.l1a));
        chk("readout_count", 64'(readout_count), 64'(mf.rdc));
        chk("crc0", 64'(crc0), 64'(mf.c0));
        chk("crc1", 64'(crc1), 64'(mf.c1));
        chk("good_frames", 64'(good_frames), 64'(mf.good));
        chk("bad_frames", 64'(bad_frames), 64'(mf.bad));
      end
    end
  end

  always @(negedge clk) begin
    if (pay_valid16) begin
      if (exp16_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL pay16_unexpected: got %0h expected none", pay_data16);
      end else chk("pay16_data", 64'(pay_data16), 64'(exp16_q.pop_front()));
    end
    if (frame_done16) begin
      if (exp16_f.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL frame16_unexpected: got err %0h expected none", err16);
      end else begin
        mf16 = exp16_f.pop_front();
        chk("err16", 64'(err16), 64'(mf16.err));
        chk("frame_ok16", 64'(frame_ok16), 64'(mf16.ok));
        chk("frame_len16", 64'(frame_len16), 64'(mf16.len));
        chk("bxn16", 64'(bxn16), 64'(mf16.bxn));
        chk("crc0_16", 64'(crc0_16), 64'(mf16.c0));
        chk("good16", 64'(good16), 64'(mf16.good));
        chk("bad16", 64'(bad16), 64'(mf16.bad));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    hard_rst = 1'b1;
    chk("rst_pay_valid", 64'(pay_valid), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_frame_len", 64'(frame_len), 64'd0);
    chk("rst_good", 64'(good_frames), 64'd0);
    chk("rst_bad", 64'(bad_frames), 64'd0);
    chk("rst_bxn", 64'(bxn_l1a), 64'd0);
    chk("rst_crc0", 64'(crc0), 64'd0);
    idle(2);

    // Clean frame, 6 body words, 14 words total
    push_frame(0, 5'b00000, 11'd14, 12'h123, 12'h045, 12'h007, CRC_A, CRC_B);
    send_hdr(0, 12'h123, 12'h045, 12'h007, 7'h0D);
    send_body(0, 6, 6);
    send_tail(0, 11'd14);
    idle(3);

    // Wrong trailing count
    push_frame(0, 5'b01000, 11'd14, 12'h123, 12'h045, 12'h007, CRC_A, CRC_B);
    send_hdr(0, 12'h123, 12'h045, 12'h007, 7'h0D);
    send_body(0, 6, 6);
    send_tail(0, 11'd13);
    idle(2);

    // Idle word after 3 body words, then clean frame with no gap
    push_frame(0, 5'b00001, 11'd7, 12'h321, 12'h054, 12'h008, CRC_A, CRC_B);
    send_hdr(0, 12'h321, 12'h054, 12'h008, 7'h0D);
    send_body(0, 3, 3);
    send(IDLE_W, 0);
    push_frame(0, 5'b00000, 11'd14, 12'hABC, 12'h001, 12'h009, CRC_A, CRC_B);
    send_hdr(0, 12'hABC, 12'h001, 12'h009, 7'h0D);
    send_body(0, 6, 6);
    send_tail(0, 11'd14);

    // Header marker inside body: abort at wc=6, second frame parsed normally
    push_frame(0, 5'b10000, 11'd6, 12'h111, 12'h222, 12'h333, CRC_A, CRC_B);
    send_hdr(0, 12'h111, 12'h222, 12'h333, 7'h0D);
    send_body(0, 2, 2);
    push_frame(0, 5'b00000, 11'd14, 12'h444, 12'h555, 12'h666, CRC_A, CRC_B);
    send_hdr(0, 12'h444, 12'h555, 12'h666, 7'h0D);
    send_body(0, 6, 6);
    send_tail(0, 11'd14);

    // Bad prefix on header word 2, then back-to-back clean frame
    push_frame(0, 5'b00010, 11'd14, 12'h123, 12'h045, 12'h007, CRC_A, CRC_B);
    send_hdr(0, 12'h123, 12'h045, 12'h007, 7'h0C);
    send_body(0, 6, 6);
    send_tail(0, 11'd14);
    push_frame(0, 5'b00000, 11'd9, 12'hFFF, 12'h000, 12'h800, CRC_A, CRC_B);
    send_hdr(0, 12'hFFF, 12'h000, 12'h800, 7'h0D);
    send_body(0, 1, 1);
    send_tail(0, 11'd9);
    idle(3);

    // Overlength on MAX_WORDS=16 instance: 11 body words forwarded, abort on the 12th
    push_frame(1, 5'b10000, 11'd16, 12'h0AA, 12'h0BB, 12'h0CC, 19'd0, 19'd0);
    send_hdr(1, 12'h0AA, 12'h0BB, 12'h0CC, 7'h0D);
    send_body(1, 20, 11);
    send_tail(1, 11'd28);
    idle(3);

    // Reset mid-body: no frame_done, counters cleared
    send_hdr(0, 12'h777, 12'h888, 12'h999, 7'h0D);
    send_body(0, 3, 3);
    hard_rst = 1'b0;
    daqp = IDLE_W;
    @(posedge clk);
    #1;
    chk("midrst_frame_done", 64'(frame_done), 64'd0);
    chk("midrst_good", 64'(good_frames), 64'd0);
    chk("midrst_bad", 64'(bad_frames), 64'd0);
    chk("midrst_state", 64'(state_dbg), 64'd0);
    chk("midrst_bad16", 64'(bad16), 64'd0);
    idle(1);
    hard_rst = 1'b1;
    eg = 16'd0;
    eb = 16'd0;
    eg16 = 16'd0;
    eb16 = 16'd0;
    push_frame(0, 5'b00000, 11'd14, 12'h123, 12'h045, 12'h007, CRC_A, CRC_B);
    send_hdr(0, 12'h123, 12'h045, 12'h007, 7'h0D);
    send_body(0, 6, 6);
    send_tail(0, 11'd14);
    idle(5);

    // Final report
    chk("pay_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("frame_queue_empty", 64'(exp_f.size()), 64'd0);
    chk("pay16_queue_empty", 64'(exp16_q.size()), 64'd0);
    chk("frame16_queue_empty", 64'(exp16_f.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
